// File: rtl/bus_arbiter_rr4_pkg.sv
// bus_arbiter_rr4_pkg: shared constants, state encodings and helpers for the 4-way round-robin arbiter
package bus_arbiter_rr4_pkg;
  localparam int N_REQ = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  function automatic logic [N_REQ-1:0] onehot(input logic [1:0] i);
    return N_REQ'(1) << i;
  endfunction
endpackage

// File: rtl/bus_arbiter_rr4_rr_pick4.sv
// bus_arbiter_rr4_rr_pick4: combinational round-robin pick, first set request at or after ptr
module bus_arbiter_rr4_rr_pick4
  import bus_arbiter_rr4_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic             any,
  output logic [1:0]       win
);
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0] rot;
  logic [1:0] idx;
  // rotate so ptr sits at bit 0, priority-encode, then rotate the index back
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N_REQ-1:0];
    idx = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    win = idx + ptr;
    any = |req;
  end
endmodule

// File: rtl/bus_arbiter_rr4.sv
// bus_arbiter_rr4: round-robin owner-holds arbiter driving a 4:1 mux select and one-hot grant
module bus_arbiter_rr4
  import bus_arbiter_rr4_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       sel,
  output logic             busy,
  output logic             timeout
);
  localparam int CW = HOLD_MAX == 0 ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] LIM = CW'(HOLD_MAX == 0 ? 0 : HOLD_MAX - 1);
  logic [1:0] state, ptr, win;
  logic [CW-1:0] cnt;
  logic any, lim, fin, to;
  bus_arbiter_rr4_rr_pick4 u_pick (.req(req), .ptr(ptr), .any(any), .win(win));
  // end-of-grant decode for the current owner (sel holds its index while granted)
  always_comb begin
    lim = (HOLD_MAX != 0) && (cnt == LIM);
    fin = done[sel] | ~req[sel] | lim;
    to = lim & req[sel] & ~done[sel];
  end
  // FSM, rotating priority pointer, hold counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      gnt <= '0;
      sel <= '0;
      busy <= 1'b0;
      timeout <= 1'b0;
      ptr <= '0;
      cnt <= '0;
    end else begin
      timeout <= 1'b0;
      if (state == ST_GRANT) begin
        if (fin) begin
          gnt <= '0;
          busy <= 1'b0;
          ptr <= sel + 2'd1;
          timeout <= to;
          state <= ST_RELEASE;
        end else begin
          cnt <= cnt + CW'(~&cnt);
        end
      end else if (any) begin
        gnt <= onehot(win);
        sel <= win;
        busy <= 1'b1;
        cnt <= '0;
        state <= ST_GRANT;
      end else begin
        state <= ST_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_bus_arbiter_rr4.sv
// tb_bus_arbiter_rr4: table-driven directed checks plus hand-written timeout sequence
module tb_bus_arbiter_rr4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] done = '0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic busy, timeout;
  int passed = 0;
  int total = 0;
  typedef struct {
    logic rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic busy;
    logic to;
  } vec_t;
  vec_t vecs[$];
  bus_arbiter_rr4 #(.HOLD_MAX(8)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .sel(sel), .busy(busy), .timeout(timeout)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] dn,
                              input logic [3:0] g, input logic [1:0] s, input logic b, input logic t);
    vec_t x;
    x.rst = r; x.req = rq; x.done = dn; x.gnt = g; x.sel = s; x.busy = b; x.to = t;
    return x;
  endfunction
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] dn);
    rst = r; req = rq; done = dn;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [3:0] g, input logic [1:0] s,
                       input logic b, input logic t);
    total++;
    if (gnt === g && sel === s && busy === b && timeout === t) passed++;
    else $display("FAIL %s: got gnt=%b sel=%0d busy=%b timeout=%b, expected gnt=%b sel=%0d busy=%b timeout=%b",
                  name, gnt, sel, busy, timeout, g, s, b, t);
  endtask
  initial begin
    // reset with all requests pending, then first grant goes to requester 0
    vecs.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001, 0, 1, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    // single requester 2, done at edge 5, sel holds, ptr moves to 3
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2, 1, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, 2, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 2, 0, 0));
    vecs.push_back(mk(0, 4'b1001, 4'b0000, 4'b1000, 3, 1, 0));
    vecs.push_back(mk(0, 4'b1001, 4'b1000, 4'b0000, 3, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 3, 0, 0));
    // fairness: order 0,1,2,3,0 with one dead cycle between grants
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001 << (i % 4), 2'(i % 4), 1, 0));
      vecs.push_back(mk(0, 4'b1111, 4'b0001 << (i % 4), 4'b0000, 2'(i % 4), 0, 0));
    end
    // stray done/req on other bits ignored; done on the last allowed cycle is a normal end
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0001, 0, 1, 0));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(0, 4'b1001, 4'b1000, 4'b0001, 0, 1, 0));
    vecs.push_back(mk(0, 4'b1001, 4'b0001, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    // reset mid-grant clears ptr so requester 0 beats 2
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2, 1, 0));
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0101, 4'b0000, 4'b0001, 0, 1, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].done);
      check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].busy, vecs[i].to);
    end
    // timeout: requester 0 holds 8 cycles, revoked with a 1-cycle pulse, then requester 1 wins
    step(1, 4'b0000, 4'b0000);
    check("to_reset", 4'b0000, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 4'b0011, 4'b0000);
      check($sformatf("to_hold%0d", i), 4'b0001, 0, 1, 0);
    end
    step(0, 4'b0011, 4'b0000);
    check("to_pulse", 4'b0000, 0, 0, 1);
    step(0, 4'b0011, 4'b0000);
    check("to_next", 4'b0010, 1, 1, 0);
    // done together with request drop is one normal end
    step(0, 4'b0000, 4'b0010);
    check("done_drop", 4'b0000, 1, 0, 0);
    step(0, 4'b0000, 4'b0000);
    check("idle_after", 4'b0000, 1, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
